// File: rtl/multimode_counter.sv
// N-bit counter with run-time selectable binary up/down, ring and Johnson modes.
// Supports clear, parallel load, binary modulus, registered terminal-count and error pulses.
module multimode_counter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         en,
    input  logic         clr,
    input  logic         load,
    input  logic [N-1:0] load_val,
    input  logic [1:0]   mode,
    input  logic [N-1:0] up_limit,
    output logic [N-1:0] q,
    output logic         tc,
    output logic         err
);

    localparam logic [1:0]   MODE_UP   = 2'b00;
    localparam logic [1:0]   MODE_DOWN = 2'b01;
    localparam logic [1:0]   MODE_RING = 2'b10;
    localparam logic [1:0]   MODE_JOHN = 2'b11;
    localparam logic [N-1:0] ONE       = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0] JOHN_LAST = {1'b1, {(N-1){1'b0}}};
    localparam logic [N-1:0] ADJ_MASK  = {1'b0, {(N-1){1'b1}}};

    logic [1:0]   mode_r;
    logic [N-1:0] q_nxt;
    logic         tc_nxt;
    logic         err_nxt;

    function automatic logic is_onehot(input logic [N-1:0] v);
        return (v != '0) && ((v & (v - ONE)) == '0);
    endfunction

    // A Johnson state has at most one boundary between adjacent differing bits.
    function automatic logic is_johnson(input logic [N-1:0] v);
        logic [N-1:0] diff;
        diff = (v ^ (v >> 1)) & ADJ_MASK;
        return (diff & (diff - ONE)) == '0;
    endfunction

    function automatic logic [N-1:0] seed(input logic [1:0] m, input logic [N-1:0] lim);
        case (m)
            MODE_DOWN: return lim;
            MODE_RING: return ONE;
            default:   return '0;
        endcase
    endfunction

    always_comb begin
        q_nxt   = q;
        tc_nxt  = 1'b0;
        err_nxt = 1'b0;
        if (clr) begin
            q_nxt = seed(mode, up_limit);
        end else if (load) begin
            case (mode)
                MODE_RING: begin
                    if (is_onehot(load_val)) q_nxt = load_val;
                    else begin
                        q_nxt   = ONE;
                        err_nxt = 1'b1;
                    end
                end
                MODE_JOHN: begin
                    if (is_johnson(load_val)) q_nxt = load_val;
                    else begin
                        q_nxt   = '0;
                        err_nxt = 1'b1;
                    end
                end
                default: begin
                    if (load_val <= up_limit) q_nxt = load_val;
                    else begin
                        q_nxt   = up_limit;
                        err_nxt = 1'b1;
                    end
                end
            endcase
        end else if (mode != mode_r) begin
            q_nxt = seed(mode, up_limit);
        end else if (en) begin
            case (mode)
                MODE_UP: begin
                    if (q >= up_limit) begin
                        q_nxt  = '0;
                        tc_nxt = 1'b1;
                    end else q_nxt = q + ONE;
                end
                MODE_DOWN: begin
                    if (q == '0) begin
                        q_nxt  = up_limit;
                        tc_nxt = 1'b1;
                    end else if (q > up_limit) q_nxt = up_limit;
                    else q_nxt = q - ONE;
                end
                MODE_RING: begin
                    if (is_onehot(q)) begin
                        q_nxt  = {q[N-2:0], q[N-1]};
                        tc_nxt = q[N-1];
                    end else begin
                        q_nxt   = ONE;
                        err_nxt = 1'b1;
                    end
                end
                default: begin
                    if (is_johnson(q)) begin
                        q_nxt  = {q[N-2:0], ~q[N-1]};
                        tc_nxt = (q == JOHN_LAST);
                    end else begin
                        q_nxt   = '0;
                        err_nxt = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q      <= '0;
            tc     <= 1'b0;
            err    <= 1'b0;
            mode_r <= MODE_UP;
        end else begin
            q      <= q_nxt;
            tc     <= tc_nxt;
            err    <= err_nxt;
            mode_r <= mode;
        end
    end

endmodule

// File: tb/tb_multimode_counter.sv
// Directed bench for multimode_counter: N=4 and N=8 instances share stimulus;
// expected q/tc/err are queued when each step is driven and compared after the edge.
module tb_multimode_counter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       en, clr, load;
    logic [1:0] mode;
    logic [7:0] load_val, up_limit;
    logic [3:0] q4;
    logic [7:0] q8;
    logic       tc4, err4, tc8, err8;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] q;
        logic       tc;
        logic       err;
        string      tag;
    } exp_t;
    exp_t sb[$];

    multimode_counter #(.N(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .en(en), .clr(clr), .load(load),
        .load_val(load_val[3:0]), .mode(mode), .up_limit(up_limit[3:0]),
        .q(q4), .tc(tc4), .err(err4)
    );

    multimode_counter #(.N(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .en(en), .clr(clr), .load(load),
        .load_val(load_val), .mode(mode), .up_limit(up_limit),
        .q(q8), .tc(tc8), .err(err8)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock step: drive at negedge, queue the expectation, compare 1 time unit after posedge.
    task automatic step(input bit s8, input logic e, input logic c, input logic l,
                        input logic [1:0] m, input logic [7:0] lv, input logic [7:0] ul,
                        input logic [7:0] eq, input logic etc, input logic eerr,
                        input string tag);
        exp_t x;
        @(negedge clk);
        en = e; clr = c; load = l; mode = m; load_val = lv; up_limit = ul;
        sb.push_back('{eq, etc, eerr, tag});
        @(posedge clk);
        #1;
        x = sb.pop_front();
        if (s8) begin
            chk({x.tag, "_q"},   q8,          x.q);
            chk({x.tag, "_tc"},  {7'b0, tc8},  {7'b0, x.tc});
            chk({x.tag, "_err"}, {7'b0, err8}, {7'b0, x.err});
        end else begin
            chk({x.tag, "_q"},   {4'b0, q4},  x.q);
            chk({x.tag, "_tc"},  {7'b0, tc4},  {7'b0, x.tc});
            chk({x.tag, "_err"}, {7'b0, err4}, {7'b0, x.err});
        end
    endtask

    localparam logic [7:0] JSEQ[8] = '{8'h1, 8'h3, 8'h7, 8'hF, 8'hE, 8'hC, 8'h8, 8'h0};

    initial begin
        reset_n = 1'b0;
        en = 0; clr = 0; load = 0; mode = 2'b00; load_val = 0; up_limit = 8'd15;
        #12;
        chk("rst_q", {4'b0, q4}, 8'h0);
        chk("rst_tc", {7'b0, tc4}, 8'h0);
        chk("rst_err", {7'b0, err4}, 8'h0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 1; i <= 7; i++) step(0, 1, 0, 0, 2'b00, 0, 15, 8'(i), 0, 0, "pre_up");

        // asynchronous reset mid-count, between clock edges
        #2;
        reset_n = 1'b0;
        en = 1'b0;
        #1;
        chk("async_rst_q", {4'b0, q4}, 8'h0);
        chk("async_rst_tc", {7'b0, tc4}, 8'h0);
        chk("async_rst_err", {7'b0, err4}, 8'h0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 1; i <= 16; i++) step(0, 1, 0, 0, 2'b00, 0, 15, 8'(i % 16), i == 16, 0, "up");

        // binary down with modulus 9, then limit dropped under q
        step(0, 1, 1, 0, 2'b01, 0, 9, 8'd9, 0, 0, "down_clr");
        for (int i = 8; i >= 0; i--) step(0, 1, 0, 0, 2'b01, 0, 9, 8'(i), 0, 0, "down");
        step(0, 1, 0, 0, 2'b01, 0, 9, 8'd9, 1, 0, "down_wrap");
        step(0, 1, 0, 0, 2'b01, 0, 9, 8'd8, 0, 0, "down_8");
        step(0, 1, 0, 0, 2'b01, 0, 5, 8'd5, 0, 0, "down_lim_drop");
        step(0, 1, 0, 0, 2'b01, 0, 5, 8'd4, 0, 0, "down_after_drop");

        // up to 6, then switch to ring
        step(0, 1, 1, 0, 2'b00, 0, 15, 8'd0, 0, 0, "up_clr");
        for (int i = 1; i <= 6; i++) step(0, 1, 0, 0, 2'b00, 0, 15, 8'(i), 0, 0, "up_to6");
        step(0, 1, 0, 0, 2'b10, 0, 15, 8'h1, 0, 0, "ring_switch");
        step(0, 1, 0, 0, 2'b10, 0, 15, 8'h2, 0, 0, "ring_2");
        step(0, 1, 0, 0, 2'b10, 0, 15, 8'h4, 0, 0, "ring_4");
        step(0, 1, 0, 0, 2'b10, 0, 15, 8'h8, 0, 0, "ring_8");
        step(0, 1, 0, 0, 2'b10, 0, 15, 8'h1, 1, 0, "ring_wrap");
        step(0, 1, 0, 1, 2'b10, 8'h6, 15, 8'h1, 0, 1, "ring_bad_load");
        step(0, 0, 0, 0, 2'b10, 0, 15, 8'h1, 0, 0, "ring_hold");
        step(0, 0, 0, 1, 2'b10, 8'h4, 15, 8'h4, 0, 0, "ring_good_load");

        // Johnson full period
        step(0, 1, 0, 0, 2'b11, 0, 15, 8'h0, 0, 0, "john_switch");
        for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 2'b11, 0, 15, JSEQ[i], i == 7, 0, "john");
        step(0, 1, 0, 1, 2'b11, 8'h5, 15, 8'h0, 0, 1, "john_bad_load");
        step(0, 0, 0, 1, 2'b11, 8'hC, 15, 8'hC, 0, 0, "john_good_load");
        step(0, 1, 0, 0, 2'b11, 0, 15, 8'h8, 0, 0, "john_8");
        step(0, 1, 0, 0, 2'b11, 0, 15, 8'h0, 1, 0, "john_wrap");

        // everything asserted at once: clr wins with the new mode's seed
        step(0, 1, 1, 1, 2'b01, 8'h5, 9, 8'd9, 0, 0, "all_same_edge");
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 2'b01, 0, 9, 8'd9, 0, 0, "hold");
        step(0, 0, 0, 1, 2'b01, 8'd3, 9, 8'd3, 0, 0, "bin_load_ok");
        step(0, 0, 0, 1, 2'b01, 8'd12, 9, 8'd9, 0, 1, "bin_load_over");

        // zero modulus
        step(0, 1, 0, 0, 2'b00, 0, 0, 8'd0, 0, 0, "ul0_switch");
        step(0, 1, 0, 0, 2'b00, 0, 0, 8'd0, 1, 0, "ul0_up_a");
        step(0, 1, 0, 0, 2'b00, 0, 0, 8'd0, 1, 0, "ul0_up_b");
        step(0, 1, 0, 0, 2'b01, 0, 0, 8'd0, 0, 0, "ul0_dn_switch");
        step(0, 1, 0, 0, 2'b01, 0, 0, 8'd0, 1, 0, "ul0_dn");

        // N=8 regression
        step(1, 1, 1, 0, 2'b00, 0, 200, 8'd0, 0, 0, "n8_clr");
        for (int i = 1; i <= 201; i++) step(1, 1, 0, 0, 2'b00, 0, 200, 8'(i % 201), i == 201, 0, "n8_up");
        step(1, 1, 0, 1, 2'b10, 8'h00, 200, 8'h01, 0, 1, "n8_ring_bad_load");
        step(1, 1, 0, 0, 2'b10, 0, 200, 8'h02, 0, 0, "n8_ring_shift");

        chk("sb_empty", 8'(sb.size()), 8'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
